// File: rtl/mul_pkg.sv
// Shared types and defaults for the shift-add multiplier core.
package mul_pkg;

    // Controller state: waiting for an operand pair, or iterating over multiplier bits.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Operand width used when the instantiating level does not override N.
    localparam int MUL_N_DEFAULT = 4;

endpackage : mul_pkg

// File: rtl/mul_core.sv
// Sequential unsigned N x N shift-add multiplier, one multiplier bit per clock,
// with a start/busy/done handshake and a 2N-bit registered product.
// Optional build macro: MUL_EARLY_EXIT_EN -- finish as soon as the remaining
// shifted multiplier is zero instead of always iterating N times.
module mul_core
    import mul_pkg::*;
#(
    parameter int N = MUL_N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] y
);

    localparam int CW = $clog2(N + 1);

    state_e           state_q,  state_d;
    logic [2*N-1:0]   mcand_q,  mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic [2*N-1:0]   acc_q,    acc_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [2*N-1:0]   y_q,      y_d;
    logic             done_q,   done_d;

    logic [2*N-1:0]   acc_sum;
    logic             last_iter;

    // Partial-product add for the current multiplier LSB and the end-of-run test.
    always_comb begin
        acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef MUL_EARLY_EXIT_EN
        // After this edge's shift the multiplier is mplier_q >> 1; stop when nothing is left.
        last_iter = (cnt_q == CW'(1)) || (mplier_q[N-1:1] == '0);
`else
        last_iter = (cnt_q == CW'(1));
`endif
    end

    // Next-state and datapath update: accept in IDLE, one shift-add step per edge in RUN.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{N{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = CW'(N);
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (last_iter) begin
                    y_d     = acc_sum;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything, aborting any run in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            y_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign y    = y_q;

endmodule : mul_core

// File: tb/tb_mul_core.sv
// Directed, table-driven bench for mul_core (N = 4), plus hand-written
// sequences for busy-start rejection, back-to-back issue and mid-run reset.
module tb_mul_core;

    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] y;

    int checks;
    int errors;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] exp_y;
    } vec_t;

    vec_t vecs[8];

    mul_core #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [N-1:0] bv);
`ifdef MUL_EARLY_EXIT_EN
        int l;
        l = 1;
        for (int i = 0; i < N; i++)
            if (bv[i]) l = i + 1;
        return l;
`else
        return N;
`endif
    endfunction

    // Present operands at the falling edge; return 1 ns after the accepting edge.
    task automatic start_op(input logic [N-1:0] av, input logic [N-1:0] bv);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen (sampled 1 ns after each edge), bounded.
    task automatic wait_done(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 4 * N + 4; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        bit          ok;
        int          ndone;
        logic [2*N-1:0] prev_y;

        checks = 0;
        errors = 0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        rst_n  = 1'b1;

        vecs[0] = '{a: 4'd0,  b: 4'd0,  exp_y: 8'd0};
        vecs[1] = '{a: 4'd15, b: 4'd15, exp_y: 8'hE1};
        vecs[2] = '{a: 4'd1,  b: 4'd15, exp_y: 8'd15};
        vecs[3] = '{a: 4'd7,  b: 4'd9,  exp_y: 8'd63};
        vecs[4] = '{a: 4'd5,  b: 4'd1,  exp_y: 8'd5};
        vecs[5] = '{a: 4'd8,  b: 4'd3,  exp_y: 8'd24};
        vecs[6] = '{a: 4'd3,  b: 4'd8,  exp_y: 8'd24};
        vecs[7] = '{a: 4'd15, b: 4'd0,  exp_y: 8'd0};

        // Asynchronous reset asserted away from any clock edge
        #3 rst_n = 1'b0;
        #1;
        check("reset_y", 64'(y), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        prev_y = '0;
        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            check($sformatf("busy_after_accept[%0d]", i), 64'(busy), 64'd1);
            check($sformatf("y_held_at_start[%0d]", i), 64'(y), 64'(prev_y));
            wait_done(lat, ok);
            check($sformatf("done_seen[%0d]", i), 64'(ok), 64'd1);
            check($sformatf("latency[%0d]", i), 64'(lat), 64'(exp_lat(vecs[i].b)));
            check($sformatf("y[%0d]", i), 64'(y), 64'(vecs[i].exp_y));
            check($sformatf("busy_on_done[%0d]", i), 64'(busy), 64'd0);
            @(posedge clk);
            #1;
            check($sformatf("done_one_cycle[%0d]", i), 64'(done), 64'd0);
            check($sformatf("y_holds[%0d]", i), 64'(y), 64'(vecs[i].exp_y));
            prev_y = vecs[i].exp_y;
        end

        // start while busy must be ignored
        start_op(4'd3, 4'd5);
        @(negedge clk);
        a     = 4'd2;
        b     = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, ok);
        check("busy_ignore_done", 64'(ok), 64'd1);
        check("busy_ignore_y", 64'(y), 64'd15);
        ndone = 0;
        for (int i = 0; i < N + 3; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("busy_ignore_no_second_done", 64'(ndone), 64'd0);
        check("busy_ignore_y_kept", 64'(y), 64'd15);

        // Back-to-back: new start presented while done is high
        start_op(4'd7, 4'd9);
        wait_done(lat, ok);
        check("b2b_first_y", 64'(y), 64'd63);
        a     = 4'd6;
        b     = 4'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_accepted_busy", 64'(busy), 64'd1);
        wait_done(lat, ok);
        check("b2b_done", 64'(ok), 64'd1);
        check("b2b_latency", 64'(lat), 64'(exp_lat(4'd6)));
        check("b2b_y", 64'(y), 64'd36);

        // Reset in the middle of a run
        start_op(4'd15, 4'd15);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrun_reset_y", 64'(y), 64'd0);
        check("midrun_reset_busy", 64'(busy), 64'd0);
        check("midrun_reset_done", 64'(done), 64'd0);
        ndone = 0;
        for (int i = 0; i < N + 2; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("midrun_no_done", 64'(ndone), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle", 64'(busy), 64'd0);
        check("post_reset_y", 64'(y), 64'd0);
        start_op(4'd4, 4'd4);
        wait_done(lat, ok);
        check("post_reset_done", 64'(ok), 64'd1);
        check("post_reset_latency", 64'(lat), 64'(exp_lat(4'd4)));
        check("post_reset_y16", 64'(y), 64'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mul_core

// File: doc/mul_core.md
Name: mul_core

Overview:
- Sequential unsigned N×N multiplier using a shift-add algorithm, one multiplier bit per clock.
- Produces a 2N-bit product with a start/done handshake.
- Arithmetic leaf block in the datapath; sits behind a register-level controller that issues operands and waits for done.

Parameters:
N, 4, operand width in bits (N ≥ 2); product width is 2N.

Ports:
clk  input  1  single system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request a multiply; sampled on rising clk edges
a  input  N  multiplicand, unsigned, captured when start is accepted
b  input  N  multiplier, unsigned, captured when start is accepted
busy  output  1  high while a multiply is in progress
done  output  1  one-cycle pulse when y holds a new result
y  output  2N  product a*b, unsigned

Behaviour:
- One clock domain.
- Reset is asynchronous and active-low: rst_n low immediately forces y=0, busy=0, done=0, state=IDLE, and clears all internal registers.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- Accept rule:
  - A rising edge with start=1 and busy=0 captures a and b, clears the accumulator, loads the iteration counter with N, and enters RUN.
  - start while busy=1 is ignored; operands are not re-captured.
- RUN, each edge:
  - If the multiplier LSB is 1, add the shifted multiplicand into the 2N-bit accumulator.
  - Shift the multiplicand left 1 and the multiplier right 1.
  - Decrement the counter.
- Completion:
  - The edge on which the counter reaches 0 writes the accumulator to y, sets done=1, and returns to IDLE with busy=0.
  - Latency is exactly N cycles from the accept edge to the done edge.
- done:
  - High for exactly one cycle.
  - start may be accepted on the cycle done is high (back-to-back operation, throughput one result per N+1 cycles).
- y holds its last result until the next completion; it is not cleared at start.
- Arithmetic:
  - Fully unsigned.
  - Accumulator is 2N bits, so no overflow: maximum (2^N−1)^2 fits.
  - Operands of 0 give y=0 with normal latency.
- Reset mid-RUN aborts the operation: no done pulse, y=0. The next start after reset release behaves normally.

Optional Feature:
MUL_EARLY_EXIT_EN
- Defined: RUN terminates on the first edge where the remaining (already shifted) multiplier equals 0.
  - Latency is max(1, index of the highest set bit of b + 1) cycles.
  - b=0 completes in 1 cycle.
  - Result and done/busy semantics are unchanged.
- Undefined: fixed N-cycle latency as above; no early-exit logic is synthesized.

Decomposition:
- Package mul_pkg:
  - state typedef enum logic {IDLE, RUN}.
  - Default width constant MUL_N_DEFAULT=4.
- Counter width $clog2(N+1) is computed locally from N.
- No sub-module is needed: the control FSM and the datapath (accumulator, shift registers, adder) live in mul_core.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> y=0, busy=0, done=0 immediately.
- a=0, b=0, start pulse -> busy=1 for 4 cycles, then done pulse with y=0.
- a=15, b=15 -> y=225 (8'hE1) after exactly 4 cycles; a=1, b=15 -> y=15; a=7, b=9 -> y=63.
- Start a=3, b=5, then pulse start with a=2, b=2 while busy -> ignored; y=15, single done pulse.
- Back-to-back: start a=6, b=6 on the done cycle of the previous op -> accepted; y=36 four cycles later.
- Reset mid-RUN: rst_n low at cycle 2 of a=15, b=15 -> no done, y=0. After release, start a=4, b=4 -> y=16. With MUL_EARLY_EXIT_EN: a=5, b=1 -> done after 1 cycle, y=5.
